// File: rtl/lsb_mem_port_pkg.sv
// Shared types and constants for the load/store-buffer memory port.
// Holds the funct3 load encodings, the FSM state type and the byte-count helper.
package lsb_mem_port_pkg;

  localparam int LSB_WIDTH_DEF  = 3;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int VAL_WIDTH_DEF  = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Address segment [17:16] that maps onto the UART.
  localparam logic [1:0] IO_SEG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } state_e;

  // Index of the last byte of an access: byte=0, half=1, word=3.
  function automatic logic [1:0] last_byte(input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b100: last_byte = 2'd0;
      3'b001, 3'b101: last_byte = 2'd1;
      default:        last_byte = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsb_mem_port_if.sv
// Request/response and RAM-bus signals between the load/store buffer, the
// memory port (slave) and the RAM/IO side.
interface lsb_mem_port_if #(
  parameter int LSB_WIDTH  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int VAL_WIDTH  = 32
);
  logic                  load_valid;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [2:0]            load_funct3;
  logic [LSB_WIDTH-1:0]  load_id;
  logic                  load_ready;
  logic                  store_valid;
  logic [ADDR_WIDTH-1:0] store_addr;
  logic [VAL_WIDTH-1:0]  store_val;
  logic [2:0]            store_funct3;
  logic                  store_ready;
  logic                  mem2lsb_load_en;
  logic [LSB_WIDTH-1:0]  mem2lsb_load_id;
  logic [VAL_WIDTH-1:0]  mem2lsb_load_val;
  logic                  mem2lsb_store_en;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  load_valid, load_addr, load_funct3, load_id,
    input  store_valid, store_addr, store_val, store_funct3,
    input  mem_din, io_buffer_full,
    output load_ready, store_ready,
    output mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val, mem2lsb_store_en,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output load_valid, load_addr, load_funct3, load_id,
    output store_valid, store_addr, store_val, store_funct3,
    output mem_din, io_buffer_full,
    input  load_ready, store_ready,
    input  mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val, mem2lsb_store_en,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/lsb_mem_port_load_extend.sv
// Sign/zero extension of assembled little-endian load bytes according to funct3.
module lsb_mem_port_load_extend
  import lsb_mem_port_pkg::*;
#(
  parameter int VAL_WIDTH = 32
) (
  input  logic [2:0]           funct3_i,
  input  logic [VAL_WIDTH-1:0] raw_i,
  output logic [VAL_WIDTH-1:0] val_o
);

  // Select extension by access size and signedness.
  always_comb begin
    val_o = raw_i;
    case (funct3_i)
      F3_LB:   val_o = {{(VAL_WIDTH-8){raw_i[7]}}, raw_i[7:0]};
      F3_LH:   val_o = {{(VAL_WIDTH-16){raw_i[15]}}, raw_i[15:0]};
      F3_LBU:  val_o = {{(VAL_WIDTH-8){1'b0}}, raw_i[7:0]};
      F3_LHU:  val_o = {{(VAL_WIDTH-16){1'b0}}, raw_i[15:0]};
      F3_LW:   val_o = raw_i;
      default: val_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsb_mem_port.sv
// Memory-side responder for the load/store buffer: serialises one load or store
// at a time onto the 8-bit RAM bus and returns tagged load data or a store-done pulse.
module lsb_mem_port
  import lsb_mem_port_pkg::*;
#(
  parameter int LSB_WIDTH  = LSB_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int VAL_WIDTH  = VAL_WIDTH_DEF
) (
  input logic           clk,
  input logic           rst_in,
  input logic           rdy_in,
  input logic           flush,
  lsb_mem_port_if.slave bus
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [LSB_WIDTH-1:0]  id_q;
  logic [1:0]            k_q;
  logic [1:0]            last_q;
  logic [1:0]            rd_off_q;
  logic                  rd_vld_q;
  logic [VAL_WIDTH-1:0]  buf_q;
  logic [VAL_WIDTH-1:0]  buf_d;
  logic [VAL_WIDTH-1:0]  st_sh_q;
  logic [VAL_WIDTH-1:0]  ext_s;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;
  logic                  wr_q;
  logic                  load_en_q;
  logic                  store_en_q;
  logic [LSB_WIDTH-1:0]  load_id_q;
  logic [VAL_WIDTH-1:0]  load_val_q;
  logic                  idle_s;
  logic                  store_go_s;
  logic                  load_go_s;
  logic                  io_block_s;
  logic                  wr_fire_s;
  logic [ADDR_WIDTH-1:0] next_a_s;

  // Handshake decode, write gating and assembly of the byte arriving on mem_din.
  always_comb begin
    idle_s     = (state_q == ST_IDLE) && rdy_in;
    store_go_s = idle_s && bus.store_valid;
    load_go_s  = idle_s && !bus.store_valid && !flush && bus.load_valid;
    io_block_s = (addr_q[17:16] == IO_SEG) && bus.io_buffer_full;
    wr_fire_s  = wr_q && rdy_in && !io_block_s;
    next_a_s   = addr_q + ADDR_WIDTH'({1'b0, k_q} + 3'd1);
    buf_d      = buf_q;
    if (rd_vld_q) begin
      buf_d[{rd_off_q, 3'b000} +: 8] = bus.mem_din;
    end else begin
      buf_d = buf_q;
    end
  end

  lsb_mem_port_load_extend #(.VAL_WIDTH(VAL_WIDTH)) u_ext (
    .funct3_i (funct3_q),
    .raw_i    (buf_d),
    .val_o    (ext_s)
  );

  assign bus.load_ready       = idle_s && !flush && !bus.store_valid;
  assign bus.store_ready      = idle_s;
  assign bus.mem_wr           = wr_fire_s;
  assign bus.mem_a            = mem_a_q;
  assign bus.mem_dout         = mem_dout_q;
  assign bus.mem2lsb_load_en  = load_en_q;
  assign bus.mem2lsb_load_id  = load_id_q;
  assign bus.mem2lsb_load_val = load_val_q;
  assign bus.mem2lsb_store_en = store_en_q;

  // Transfer FSM with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      funct3_q   <= 3'd0;
      id_q       <= {LSB_WIDTH{1'b0}};
      k_q        <= 2'd0;
      last_q     <= 2'd0;
      rd_off_q   <= 2'd0;
      rd_vld_q   <= 1'b0;
      buf_q      <= {VAL_WIDTH{1'b0}};
      st_sh_q    <= {VAL_WIDTH{1'b0}};
      mem_a_q    <= {ADDR_WIDTH{1'b0}};
      mem_dout_q <= 8'd0;
      wr_q       <= 1'b0;
      load_en_q  <= 1'b0;
      store_en_q <= 1'b0;
      load_id_q  <= {LSB_WIDTH{1'b0}};
      load_val_q <= {VAL_WIDTH{1'b0}};
    end else begin
      load_en_q  <= 1'b0;
      store_en_q <= 1'b0;
      // Read tracking follows the RAM even through stalls, so a byte already
      // in flight on mem_din is never lost while the address is held.
      if (state_q == ST_LOAD) begin
        rd_vld_q <= 1'b1;
        rd_off_q <= k_q;
        buf_q    <= buf_d;
      end else begin
        rd_vld_q <= 1'b0;
      end
      if (rdy_in) begin
        case (state_q)
          ST_IDLE: begin
            if (store_go_s) begin
              state_q    <= ST_STORE;
              addr_q     <= bus.store_addr;
              last_q     <= last_byte(bus.store_funct3);
              k_q        <= 2'd0;
              mem_a_q    <= bus.store_addr;
              mem_dout_q <= bus.store_val[7:0];
              st_sh_q    <= bus.store_val >> 4'd8;
              wr_q       <= 1'b1;
            end else if (load_go_s) begin
              state_q  <= ST_LOAD;
              addr_q   <= bus.load_addr;
              funct3_q <= bus.load_funct3;
              id_q     <= bus.load_id;
              last_q   <= last_byte(bus.load_funct3);
              k_q      <= 2'd0;
              mem_a_q  <= bus.load_addr;
            end
          end
          ST_LOAD: begin
            if (flush) begin
              state_q <= ST_IDLE;
            end else if (rd_vld_q && (rd_off_q == last_q)) begin
              state_q    <= ST_IDLE;
              load_en_q  <= 1'b1;
              load_id_q  <= id_q;
              load_val_q <= ext_s;
            end else if (k_q != last_q) begin
              k_q     <= k_q + 2'd1;
              mem_a_q <= next_a_s;
            end
          end
          ST_STORE: begin
            if (wr_fire_s) begin
              if (k_q == last_q) begin
                state_q    <= ST_IDLE;
                wr_q       <= 1'b0;
                store_en_q <= 1'b1;
              end else begin
                k_q        <= k_q + 2'd1;
                mem_a_q    <= next_a_s;
                mem_dout_q <= st_sh_q[7:0];
                st_sh_q    <= st_sh_q >> 4'd8;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed self-checking bench for lsb_mem_port with a byte-wide RAM model.
module tb_lsb_mem_port;
  import lsb_mem_port_pkg::*;

  logic clk = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ram [0:4095];

  lsb_mem_port_if #(.LSB_WIDTH(3), .ADDR_WIDTH(32), .VAL_WIDTH(32)) bus ();

  lsb_mem_port #(.LSB_WIDTH(3), .ADDR_WIDTH(32), .VAL_WIDTH(32)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // RAM: write when mem_wr, read data valid one cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[11:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue_load(input logic [31:0] a, input logic [2:0] f3, input logic [2:0] id);
    bus.load_addr = a; bus.load_funct3 = f3; bus.load_id = id; bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic issue_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] v);
    bus.store_addr = a; bus.store_funct3 = f3; bus.store_val = v; bus.store_valid = 1'b1;
    tick();
    bus.store_valid = 1'b0;
  endtask

  // Called in the first cycle after acceptance; result expected in cycle lat.
  task automatic wait_load(input string tag, input int lat, input logic [31:0] v, input logic [2:0] id);
    for (int i = 2; i < lat; i++) tick();
    chk({tag, "_early"}, 64'(bus.mem2lsb_load_en), 64'd0);
    tick();
    chk({tag, "_en"}, 64'(bus.mem2lsb_load_en), 64'd1);
    chk({tag, "_val"}, 64'(bus.mem2lsb_load_val), 64'(v));
    chk({tag, "_id"}, 64'(bus.mem2lsb_load_id), 64'(id));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h110] = 8'h80;
    ram[12'h120] = 8'h01; ram[12'h121] = 8'h80;
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
    bus.load_valid = 1'b0; bus.load_addr = 32'd0; bus.load_funct3 = 3'd0; bus.load_id = 3'd0;
    bus.store_valid = 1'b0; bus.store_addr = 32'd0; bus.store_val = 32'd0; bus.store_funct3 = 3'd0;
    bus.io_buffer_full = 1'b0;

    tick(); tick();
    chk("rst_mem_a", 64'(bus.mem_a), 64'd0);
    chk("rst_mem_dout", 64'(bus.mem_dout), 64'd0);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_load_en", 64'(bus.mem2lsb_load_en), 64'd0);
    chk("rst_store_en", 64'(bus.mem2lsb_store_en), 64'd0);
    chk("rst_load_val", 64'(bus.mem2lsb_load_val), 64'd0);
    chk("rst_load_id", 64'(bus.mem2lsb_load_id), 64'd0);
    rst_in = 1'b1;
    #1;
    chk("rst_load_ready", 64'(bus.load_ready), 64'd1);
    chk("rst_store_ready", 64'(bus.store_ready), 64'd1);

    // LW 0x100 id 5
    tick();
    issue_load(32'h100, F3_LW, 3'd5);
    for (int k = 0; k < 4; k++) begin
      chk("lw_mem_a", 64'(bus.mem_a), 64'(32'h100 + 32'(k)));
      chk("lw_mem_wr", 64'(bus.mem_wr), 64'd0);
      if (k < 3) tick();
    end
    tick(); // cycle T+5
    chk("lw_early", 64'(bus.mem2lsb_load_en), 64'd0);
    tick(); // cycle T+6
    chk("lw_en", 64'(bus.mem2lsb_load_en), 64'd1);
    chk("lw_val", 64'(bus.mem2lsb_load_val), 64'h44332211);
    chk("lw_id", 64'(bus.mem2lsb_load_id), 64'd5);
    chk("lw_ready_again", 64'(bus.load_ready), 64'd1);
    tick();
    chk("lw_pulse_one", 64'(bus.mem2lsb_load_en), 64'd0);
    chk("lw_val_held", 64'(bus.mem2lsb_load_val), 64'h44332211);

    // LB / LBU / LH
    issue_load(32'h110, F3_LB, 3'd2);
    wait_load("lb", 3, 32'hFFFFFF80, 3'd2);
    issue_load(32'h110, F3_LBU, 3'd3);
    wait_load("lbu", 3, 32'h00000080, 3'd3);
    issue_load(32'h120, F3_LH, 3'd7);
    wait_load("lh", 4, 32'hFFFF8001, 3'd7);

    // SW 0xDEADBEEF to 0x200
    tick();
    issue_store(32'h200, 3'b010, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      chk("sw_mem_a", 64'(bus.mem_a), 64'(32'h200 + 32'(k)));
      chk("sw_mem_wr", 64'(bus.mem_wr), 64'd1);
      chk("sw_store_en_low", 64'(bus.mem2lsb_store_en), 64'd0);
      tick();
    end
    chk("sw_store_en", 64'(bus.mem2lsb_store_en), 64'd1);
    chk("sw_wr_off", 64'(bus.mem_wr), 64'd0);
    chk("sw_store_ready", 64'(bus.store_ready), 64'd1);
    chk("sw_ram", 64'({ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}), 64'hDEADBEEF);

    // Simultaneous load and store: store first
    tick();
    bus.load_addr = 32'h100; bus.load_funct3 = F3_LW; bus.load_id = 3'd1; bus.load_valid = 1'b1;
    bus.store_addr = 32'h210; bus.store_funct3 = 3'b000; bus.store_val = 32'h0000005A; bus.store_valid = 1'b1;
    #1;
    chk("both_load_ready", 64'(bus.load_ready), 64'd0);
    chk("both_store_ready", 64'(bus.store_ready), 64'd1);
    tick();
    bus.store_valid = 1'b0;
    chk("both_store_wr", 64'(bus.mem_wr), 64'd1);
    chk("both_store_a", 64'(bus.mem_a), 64'h210);
    chk("both_load_blocked", 64'(bus.load_ready), 64'd0);
    tick();
    chk("both_store_en", 64'(bus.mem2lsb_store_en), 64'd1);
    chk("both_load_ready2", 64'(bus.load_ready), 64'd1);
    tick();
    bus.load_valid = 1'b0;
    chk("both_load_a", 64'(bus.mem_a), 64'h100);
    wait_load("both_lw", 6, 32'h44332211, 3'd1);
    chk("both_ram", 64'(ram[12'h210]), 64'h5A);

    // Flush in the second cycle of an LW
    tick();
    issue_load(32'h100, F3_LW, 3'd4);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_idle_ready", 64'(bus.load_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("flush_no_pulse", 64'(bus.mem2lsb_load_en), 64'd0);
      tick();
    end

    // Flush during SH: store still completes
    issue_store(32'h220, 3'b001, 32'h00001234);
    flush = 1'b1;
    chk("shf_b0", 64'({bus.mem_wr, bus.mem_a[11:0], bus.mem_dout}), 64'({1'b1, 12'h220, 8'h34}));
    tick();
    chk("shf_b1", 64'({bus.mem_wr, bus.mem_a[11:0], bus.mem_dout}), 64'({1'b1, 12'h221, 8'h12}));
    tick();
    flush = 1'b0;
    chk("shf_store_en", 64'(bus.mem2lsb_store_en), 64'd1);
    chk("shf_ram", 64'({ram[12'h221], ram[12'h220]}), 64'h1234);

    // SB to the IO segment with io_buffer_full for three cycles
    tick();
    bus.io_buffer_full = 1'b1;
    issue_store(32'h30000, 3'b000, 32'h000000A5);
    for (int i = 0; i < 3; i++) begin
      chk("io_stall_wr", 64'(bus.mem_wr), 64'd0);
      chk("io_stall_a", 64'(bus.mem_a), 64'h30000);
      tick();
    end
    chk("io_not_written", 64'(ram[12'h000]), 64'd0);
    bus.io_buffer_full = 1'b0;
    #1;
    chk("io_wr_resume", 64'({bus.mem_wr, bus.mem_dout}), 64'({1'b1, 8'hA5}));
    tick();
    chk("io_store_en", 64'(bus.mem2lsb_store_en), 64'd1);
    chk("io_ram", 64'(ram[12'h000]), 64'hA5);

    // rdy_in low for one cycle mid-LW adds one cycle, data unchanged
    tick();
    issue_load(32'h100, F3_LW, 3'd6);
    tick();
    rdy_in = 1'b0;
    #1;
    chk("rdy_hold_wr", 64'(bus.mem_wr), 64'd0);
    tick();
    rdy_in = 1'b1;
    wait_load("rdy_lw", 5, 32'h44332211, 3'd6);

    // rdy_in low in IDLE drops both readies
    tick();
    rdy_in = 1'b0;
    #1;
    chk("rdy_low_lready", 64'(bus.load_ready), 64'd0);
    chk("rdy_low_sready", 64'(bus.store_ready), 64'd0);
    rdy_in = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
